// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and sizing helpers for the serial adder
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nbeats(input int width, input int digit);
        return width / digit;
    endfunction

    // Beat counter is never narrower than one bit, even for a single beat.
    function automatic int cnt_width(input int width, input int digit);
        return (width / digit) <= 1 ? 1 : $clog2(width / digit);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// digit_adder: combinational DIGIT-bit full adder slice with carry in/out
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT{1'b0}}, cin_i};

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract, DIGIT bits per clock through a registered carry
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int NBEATS = nbeats(WIDTH, DIGIT);
    localparam int CW     = cnt_width(WIDTH, DIGIT);

    if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             last;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a_i   (a_q[DIGIT-1:0]),
        .b_i   (b_q[DIGIT-1:0]),
        .cin_i (cy_q),
        .sum_o (dsum),
        .cout_o(dcout)
    );

    assign last      = cnt_q == CW'(NBEATS - 1);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // On the final beat the low digit of each operand register still holds the
    // original top digit, so its MSB is the operand sign used for overflow.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    cy_d    = sub;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                acc_d = WIDTH'({dsum, acc_q} >> DIGIT);
                cy_d  = dcout;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    sum_d   = WIDTH'({dsum, acc_q} >> DIGIT);
                    carry_d = dcout;
                    ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1]) & (dsum[DIGIT-1] != a_q[DIGIT-1]);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomised checks of serial_adder at DIGIT=1 and DIGIT=4
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic       sub;
    logic       iv [2];
    logic       orr [2];
    logic       ir [2];
    logic       ovd [2];
    logic [7:0] s [2];
    logic       c [2];
    logic       o [2];
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .sub(sub),
        .out_valid(ovd[0]), .out_ready(orr[0]), .sum(s[0]), .carry(c[0]), .ovf(o[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b), .sub(sub),
        .out_valid(ovd[1]), .out_ready(orr[1]), .sum(s[1]), .carry(c[1]), .ovf(o[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation on instance d, hold the result for `hold` cycles while
    // offering fresh operands, then complete the output handshake.
    task automatic op(input int d, input logic [7:0] aa, input logic [7:0] bb, input logic ss,
                      input logic [7:0] es, input logic ec, input logic eo, input int hold,
                      input string tag);
        int lat;
        int w;
        w = 0;
        while (!ir[d] && w < 32) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " ready"}, 32'(ir[d]), 32'd1);
        a = aa; b = bb; sub = ss; iv[d] = 1'b1;
        @(negedge clk);
        iv[d] = 1'b0;
        lat = 0;
        while (!ovd[d] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), d ? 32'd2 : 32'd8);
        chk({tag, " sum"}, 32'(s[d]), 32'(es));
        chk({tag, " carry"}, 32'(c[d]), 32'(ec));
        chk({tag, " ovf"}, 32'(o[d]), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            a = ~aa; b = bb ^ 8'h5A; sub = ~ss; iv[d] = 1'b1;
            @(negedge clk);
            chk({tag, " hold in_ready"}, 32'(ir[d]), 32'd0);
            chk({tag, " hold out_valid"}, 32'(ovd[d]), 32'd1);
            chk({tag, " hold sum"}, 32'(s[d]), 32'(es));
        end
        iv[d] = 1'b0;
        orr[d] = 1'b1;
        @(negedge clk);
        orr[d] = 1'b0;
        chk({tag, " back to idle"}, 32'(ir[d]), 32'd1);
        chk({tag, " out_valid low"}, 32'(ovd[d]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ra, rb, es;
        logic       rs, ec, eo;
        rst_n = 1'b0; a = '0; b = '0; sub = 1'b0;
        iv[0] = 1'b0; iv[1] = 1'b0; orr[0] = 1'b0; orr[1] = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset in_ready", 32'(ir[d]), 32'd1);
            chk("reset out_valid", 32'(ovd[d]), 32'd0);
            chk("reset sum", 32'(s[d]), 32'd0);
            chk("reset carry", 32'(c[d]), 32'd0);
            chk("reset ovf", 32'(o[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        op(0, 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 0, "add 3C+05");
        op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, "add FF+01");
        op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, "add 7F+01");
        op(0, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0, "sub 05-07");
        op(0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0, "sub 80-01");
        op(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 5, "backpressure 12+34");
        op(0, 8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0, 0, "after backpressure C0+C0");

        a = 8'hAA; b = 8'h55; sub = 1'b0; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(ovd[0]), 32'd0);
        chk("abort sum", 32'(s[0]), 32'd0);
        chk("abort in_ready", 32'(ir[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-abort idle", 32'(ovd[0]), 32'd0);
        op(0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0, "post-abort 10+20");

        op(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, "d4 add 7F+01");
        op(1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 2, "d4 sub 05-07");
        op(1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0, "d4 sub 80-01");

        for (int k = 0; k < 500; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            es = rs ? ra - rb : ra + rb;
            ec = rs ? (ra >= rb) : (({1'b0, ra} + {1'b0, rb}) > 9'd255);
            eo = rs ? ((ra[7] != rb[7]) && (es[7] != ra[7])) : ((ra[7] == rb[7]) && (es[7] != ra[7]));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            op(1, ra, rb, rs, es, ec, eo, $urandom_range(0, 3), "d4 random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
